// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma block-copy / fill initiator.
package mem_dma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    localparam int DEFAULT_ADDR_WIDTH = 16;

endpackage

// File: rtl/mem_dma.sv
// Byte-wide memory initiator: copies a block (read/write alternating) or fills
// a range with a constant, then pulses done for one cycle.
module mem_dma
    import mem_dma_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [7:0]            fill_byte,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_write_byte,
    input  logic [7:0]            mem_read_byte
);

    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_reg;
    logic                    mode_reg;
    logic [ADDR_WIDTH-1:0]   src_reg;
    logic [ADDR_WIDTH-1:0]   dst_reg;
    logic [ADDR_WIDTH-1:0]   len_reg;
    logic [7:0]              fill_reg;
    logic [ADDR_WIDTH-1:0]   idx_reg;
    logic [7:0]              data_reg;
    logic [ADDR_WIDTH-1:0]   idx_next;

    assign idx_next = idx_reg + IDX_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mode_reg  <= MODE_COPY;
            src_reg   <= '0;
            dst_reg   <= '0;
            len_reg   <= '0;
            fill_reg  <= '0;
            idx_reg   <= '0;
            data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        mode_reg <= mode;
                        src_reg  <= src_addr;
                        dst_reg  <= dst_addr;
                        len_reg  <= length;
                        fill_reg <= fill_byte;
                        idx_reg  <= '0;
                        if (length == '0)
                            state_reg <= DONE;
                        else if (mode == MODE_FILL)
                            state_reg <= WRITE;
                        else
                            state_reg <= READ;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                READ: begin
                    data_reg  <= mem_read_byte;
                    state_reg <= WRITE;
                end
                WRITE: begin
                    // idx stops at length-1, so idx_next never overflows here
                    if (idx_next == len_reg) begin
                        state_reg <= DONE;
                    end else begin
                        idx_reg   <= idx_next;
                        state_reg <= (mode_reg == MODE_FILL) ? WRITE : READ;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = (state_reg == READ) || (state_reg == WRITE);
    assign done = (state_reg == DONE);

    // Bus outputs depend only on registered state, so start never reaches them combinationally
    always_comb begin
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_byte = '0;
        case (state_reg)
            READ: begin
                mem_read = 1'b1;
                mem_addr = src_reg + idx_reg;
            end
            WRITE: begin
                mem_write      = 1'b1;
                mem_addr       = dst_reg + idx_reg;
                mem_write_byte = (mode_reg == MODE_FILL) ? fill_reg : data_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_dma.sv
// Directed testbench for mem_dma with a byte-wide memory model attached.
module tb_mem_dma;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] length;
    logic [7:0]  fill_byte;
    logic        busy;
    logic        done;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_write_byte;
    logic [7:0]  mem_read_byte;

    logic [7:0] mem [0:65535];

    int vectors = 0;
    int miscompares = 0;

    int        rd_cnt, wr_cnt, both_cnt, done_cnt, cycles;
    logic      busy_seen;
    logic [15:0] seq;

    always #5 clk = ~clk;

    mem_dma #(.ADDR_WIDTH(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mode           (mode),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .length         (length),
        .fill_byte      (fill_byte),
        .busy           (busy),
        .done           (done),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_byte (mem_write_byte),
        .mem_read_byte  (mem_read_byte)
    );

    assign mem_read_byte = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write) mem[mem_addr] = mem_write_byte;
    end

    always @(negedge clk) begin
        if (mem_read) rd_cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read || mem_write) seq = {seq[14:0], mem_write};
        if (mem_read && mem_write) both_cnt++;
        if (busy) busy_seen = 1'b1;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0; done_cnt = 0;
        busy_seen = 1'b0; seq = '0;
    endtask

    // Runs one transfer; at cycle 'poke' a conflicting start is injected.
    task automatic run_xfer(input logic m, input logic [15:0] s, input logic [15:0] d,
                            input logic [15:0] l, input logic [7:0] f, input int poke);
        @(negedge clk);
        mode = m; src_addr = s; dst_addr = d; length = l; fill_byte = f; start = 1'b1;
        clear_mon();
        @(posedge clk); #1;
        start = 1'b0;
        mode = ~m; src_addr = 16'hDEAD; dst_addr = 16'hBEEF; length = 16'h0007; fill_byte = 8'hC3;
        cycles = 1;
        while (!done && cycles < 200) begin
            if (cycles == poke) begin
                start = 1'b1; mode = 1'b1; dst_addr = 16'h0300; length = 16'd2; fill_byte = 8'h77;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cycles++;
        end
        $display("xfer mode=%0d src=%04h dst=%04h len=%0d cycles=%0d rd=%0d wr=%0d",
                 m, s, d, l, cycles, rd_cnt, wr_cnt);
        check("done_seen", done, 1'b1);
        @(posedge clk); #1;
        check("done_one_cycle", done, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        rst_n = 1'b0; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0; fill_byte = '0;
        clear_mon();
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_rd", mem_read, 1'b0);
        check("rst_wr", mem_write, 1'b0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_wbyte", mem_write_byte, 8'h00);
        rst_n = 1'b1;

        // Copy 4 bytes
        mem[16'h0010] = 8'hAA; mem[16'h0011] = 8'hBB; mem[16'h0012] = 8'hCC; mem[16'h0013] = 8'hDD;
        run_xfer(1'b0, 16'h0010, 16'h0100, 16'd4, 8'h00, -1);
        check("copy_lat", cycles, 9);
        check("copy_b0", mem[16'h0100], 8'hAA);
        check("copy_b1", mem[16'h0101], 8'hBB);
        check("copy_b2", mem[16'h0102], 8'hCC);
        check("copy_b3", mem[16'h0103], 8'hDD);
        check("copy_seq", seq, 16'h0055);
        check("copy_rd", rd_cnt, 4);
        check("copy_wr", wr_cnt, 4);
        check("copy_both", both_cnt, 0);

        // Fill 3 bytes
        mem[16'h0203] = 8'hEE;
        run_xfer(1'b1, 16'h1234, 16'h0200, 16'd3, 8'h5A, -1);
        check("fill_lat", cycles, 4);
        check("fill_b0", mem[16'h0200], 8'h5A);
        check("fill_b1", mem[16'h0201], 8'h5A);
        check("fill_b2", mem[16'h0202], 8'h5A);
        check("fill_keep", mem[16'h0203], 8'hEE);
        check("fill_rd", rd_cnt, 0);
        check("fill_wr", wr_cnt, 3);

        // Zero length
        run_xfer(1'b0, 16'h0010, 16'h0400, 16'd0, 8'h00, -1);
        check("zero_lat", cycles, 1);
        check("zero_busy", busy_seen, 1'b0);
        check("zero_strobes", rd_cnt + wr_cnt, 0);

        // Destination wraps past 0xFFFF
        mem[16'h0030] = 8'h01; mem[16'h0031] = 8'h02; mem[16'h0032] = 8'h03; mem[16'h0033] = 8'h04;
        run_xfer(1'b0, 16'h0030, 16'hFFFE, 16'd4, 8'h00, -1);
        check("wrap_fffe", mem[16'hFFFE], 8'h01);
        check("wrap_ffff", mem[16'hFFFF], 8'h02);
        check("wrap_0000", mem[16'h0000], 8'h03);
        check("wrap_0001", mem[16'h0001], 8'h04);

        // Forward overlap replicates the pattern
        mem[16'h0020] = 8'h11; mem[16'h0021] = 8'h22; mem[16'h0022] = 8'h00;
        run_xfer(1'b0, 16'h0020, 16'h0021, 16'd2, 8'h00, -1);
        check("ovl_21", mem[16'h0021], 8'h11);
        check("ovl_22", mem[16'h0022], 8'h11);

        // Start mid-copy is ignored
        mem[16'h0040] = 8'h91; mem[16'h0041] = 8'h92; mem[16'h0042] = 8'h93; mem[16'h0043] = 8'h94;
        mem[16'h0300] = 8'hEE;
        run_xfer(1'b0, 16'h0040, 16'h0140, 16'd4, 8'h00, 3);
        check("dist_lat", cycles, 9);
        check("dist_b0", mem[16'h0140], 8'h91);
        check("dist_b3", mem[16'h0143], 8'h94);
        check("dist_keep", mem[16'h0300], 8'hEE);
        check("dist_wr", wr_cnt, 4);

        // Reset during a WRITE cycle
        mem[16'h0050] = 8'hA1; mem[16'h0051] = 8'hA2; mem[16'h0052] = 8'hA3; mem[16'h0053] = 8'hA4;
        mem[16'h0150] = 8'hEE; mem[16'h0151] = 8'hEE;
        @(negedge clk);
        mode = 1'b0; src_addr = 16'h0050; dst_addr = 16'h0150; length = 16'd4; start = 1'b1;
        clear_mon();
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_wr_before", mem_write, 1'b1);
        check("abort_addr_before", mem_addr, 16'h0151);
        rst_n = 1'b0;
        #1;
        check("abort_wr", mem_write, 1'b0);
        check("abort_addr", mem_addr, 16'h0000);
        check("abort_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_b0", mem[16'h0150], 8'hA1);
        check("abort_b1", mem[16'h0151], 8'hEE);
        $display("xfer aborted by reset src=0050 dst=0150 len=4");
        rst_n = 1'b1;

        // Fresh transfer after reset
        run_xfer(1'b1, 16'h0000, 16'h0160, 16'd2, 8'h3C, -1);
        check("post_lat", cycles, 3);
        check("post_b0", mem[16'h0160], 8'h3C);
        check("post_b1", mem[16'h0161], 8'h3C);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
